// File: rtl/cpu.sv
// Small 8-bit-register CPU with a 4 KiB internal byte memory and 16-bit big-endian instructions.
// Each instruction takes FETCH_HI, FETCH_LO and EXEC; Fx55/Fx65 stay in EXEC for one cycle per register.
module cpu #(
   parameter logic [11:0] RESET_PC = 12'h100
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] pc
);
   localparam int unsigned AW        = 12;
   localparam int unsigned DW        = 8;
   localparam int unsigned MEM_DEPTH = 4096;
   localparam int unsigned NREG      = 16;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      FETCH_HI = 2'd0,
      FETCH_LO = 2'd1,
      EXEC     = 2'd2,
      HALT     = 2'd3
   } state_t;

   logic [DW-1:0] mem [0:MEM_DEPTH-1];

   state_t        state_r;
   state_t        state_nx;
   logic [AW-1:0] pc_q;
   logic [15:0]   lfsr_q;
   logic [15:0]   ir;
   logic [DW-1:0] v [0:NREG-1];
   logic [AW-1:0] i_r;
   logic [AW-1:0] stack [0:NREG-1];
   logic [3:0]    sp;
   logic [3:0]    lc;

   // pc and LFSR are stored relative to their start values so an all-zero flop power-up
   // yields pc = RESET_PC, a live LFSR seed and state FETCH_HI without needing a reset.
   logic [AW-1:0] pc_r;
   logic [15:0]   lfsr;
   logic [15:0]   lfsr_nx;
   assign pc_r    = pc_q ^ RESET_PC;
   assign lfsr    = lfsr_q ^ LFSR_SEED;
   assign lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
   assign pc      = {4'h0, pc_r};

   logic [3:0]    op;
   logic [3:0]    x;
   logic [3:0]    y;
   logic [3:0]    n;
   logic [AW-1:0] nnn;
   logic [DW-1:0] kk;
   logic [DW-1:0] vx;
   logic [DW-1:0] vy;
   assign op  = ir[15:12];
   assign x   = ir[11:8];
   assign y   = ir[7:4];
   assign n   = ir[3:0];
   assign nnn = ir[11:0];
   assign kk  = ir[7:0];
   assign vx  = v[x];
   assign vy  = v[y];

   logic [AW-1:0] pc_p1;
   logic [AW-1:0] pc_p2;
   logic [AW-1:0] pc_p4;
   logic [AW-1:0] ldst_addr;
   logic [3:0]    sp_m1;
   logic          is_ret;
   logic          is_exit;
   logic          is_st;
   logic          is_ld;
   logic          loop_more;
   assign pc_p1     = pc_r + 12'd1;
   assign pc_p2     = pc_r + 12'd2;
   assign pc_p4     = pc_r + 12'd4;
   assign ldst_addr = i_r + 12'(lc);
   assign sp_m1     = sp - 4'd1;
   assign is_ret    = (ir == 16'h00EE);
   assign is_exit   = (ir == 16'h00FD);
   assign is_st     = (op == 4'hF) && (kk == 8'h55);
   assign is_ld     = (op == 4'hF) && (kk == 8'h65);
   assign loop_more = (is_st || is_ld) && (lc != x);

   // 8xyN arithmetic: result plus optional VF flag, both from pre-instruction operands
   logic [DW-1:0] alu_res;
   logic          alu_flag;
   logic          alu_we;
   logic          alu_wf;
   logic [DW:0]   sum;
   always_comb begin
      alu_res  = vy;
      alu_flag = 1'b0;
      alu_we   = 1'b1;
      alu_wf   = 1'b0;
      sum      = {1'b0, vx} + {1'b0, vy};
      case (n)
         4'h0: alu_res = vy;
         4'h1: alu_res = vx | vy;
         4'h2: alu_res = vx & vy;
         4'h3: alu_res = vx ^ vy;
         4'h4: begin alu_res = sum[DW-1:0]; alu_flag = sum[DW];   alu_wf = 1'b1; end
         4'h5: begin alu_res = vx - vy;     alu_flag = (vx >= vy); alu_wf = 1'b1; end
         4'h6: begin alu_res = {1'b0, vx[7:1]}; alu_flag = vx[0];  alu_wf = 1'b1; end
         4'h7: begin alu_res = vy - vx;     alu_flag = (vy >= vx); alu_wf = 1'b1; end
         4'hE: begin alu_res = {vx[6:0], 1'b0}; alu_flag = vx[7];  alu_wf = 1'b1; end
         default: alu_we = 1'b0;
      endcase
   end

   // next pc for the EXEC cycle
   logic [AW-1:0] pc_nx;
   always_comb begin
      pc_nx = pc_p2;
      case (op)
         4'h0: begin
            if (is_ret)  pc_nx = stack[sp_m1];
            if (is_exit) pc_nx = pc_r;
         end
         4'h1: pc_nx = nnn;
         4'h2: pc_nx = nnn;
         4'h3: if (vx == kk) pc_nx = pc_p4;
         4'h4: if (vx != kk) pc_nx = pc_p4;
         4'h5: if ((n == 4'h0) && (vx == vy)) pc_nx = pc_p4;
         4'h9: if ((n == 4'h0) && (vx != vy)) pc_nx = pc_p4;
         4'hB: pc_nx = nnn + 12'(v[0]);
         4'hF: if (loop_more) pc_nx = pc_r;
         default: pc_nx = pc_p2;
      endcase
   end

   always_comb begin
      state_nx = state_r;
      case (state_r)
         FETCH_HI: state_nx = FETCH_LO;
         FETCH_LO: state_nx = EXEC;
         EXEC: begin
            if (is_exit)        state_nx = HALT;
            else if (loop_more) state_nx = EXEC;
            else                state_nx = FETCH_HI;
         end
         HALT:    state_nx = HALT;
         default: state_nx = FETCH_HI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_r <= FETCH_HI;
      else       state_r <= state_nx;
   end

   // architectural registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= '0;
         lfsr_q <= '0;
         sp     <= '0;
         i_r    <= '0;
         lc     <= '0;
         for (int k = 0; k < NREG; k++) v[k] <= '0;
      end else begin
         lfsr_q <= lfsr_nx ^ LFSR_SEED;
         if (state_r == EXEC) begin
            pc_q <= pc_nx ^ RESET_PC;
            lc   <= loop_more ? (lc + 4'd1) : 4'd0;
            case (op)
               4'h0: if (is_ret) sp <= sp_m1;
               4'h2: sp <= sp + 4'd1;
               4'h6: v[x] <= kk;
               4'h7: v[x] <= vx + kk;
               4'h8: begin
                  if (alu_we) v[x]  <= alu_res;
                  if (alu_wf) v[15] <= {7'd0, alu_flag};
               end
               4'hA: i_r  <= nnn;
               4'hC: v[x] <= lfsr[7:0] & kk;
               4'hF: begin
                  if (kk == 8'h1E) i_r   <= i_r + 12'(vx);
                  if (is_ld)       v[lc] <= mem[ldst_addr];
               end
               default: ;
            endcase
         end
      end
   end

   // instruction latch, call stack and memory are not cleared by reset
   always_ff @(posedge clk) begin
      if (state_r == FETCH_HI) ir[15:8] <= mem[pc_r];
      if (state_r == FETCH_LO) ir[7:0]  <= mem[pc_p1];
      if (!reset && (state_r == EXEC)) begin
         if (op == 4'h2) stack[sp]       <= pc_p2;
         if (is_st)      mem[ldst_addr] <= v[lc];
      end
   end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: loads small programs into cpu0.mem and checks pc, registers and memory
// against hand-computed values.
module tb_cpu;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] pc;

   int checks = 0;
   int errors = 0;

   localparam logic [15:0] ST_FETCH_HI = 16'd0;
   localparam logic [15:0] ST_EXEC     = 16'd2;
   localparam logic [15:0] ST_HALT     = 16'd3;

   logic [15:0] exp_trace [6] = '{16'h0100, 16'h0104, 16'h0108, 16'h010A, 16'h010E, 16'h0106};

   cpu #(.RESET_PC(12'h100)) cpu0 (
      .clk   (clk),
      .reset (reset),
      .pc    (pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int cnt);
      repeat (cnt) @(negedge clk);
   endtask

   task automatic put(input logic [11:0] a, input logic [15:0] w);
      cpu0.mem[a]         = w[15:8];
      cpu0.mem[a + 12'd1] = w[7:0];
   endtask

   // hold reset and clear memory so a fresh program can be placed
   task automatic begin_load();
      @(negedge clk);
      reset = 1'b1;
      for (int a = 0; a < 4096; a++) cpu0.mem[a] = 8'h00;
   endtask

   task automatic start();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_to_halt(input int budget, input string tag);
      int c;
      c = 0;
      while ((16'(cpu0.state_r) != ST_HALT) && (c < budget)) begin
         @(negedge clk);
         c++;
      end
      check(tag, 16'(cpu0.state_r), ST_HALT);
   endtask

   initial begin
      int k;

      // power-up values, no reset applied yet
      #1;
      check("powerup_pc", pc, 16'h0100);
      check("powerup_state", 16'(cpu0.state_r), ST_FETCH_HI);

      // call / skip / return / exit trace
      begin_load();
      put(12'h100, 16'h1104);
      put(12'h104, 16'h2108);
      put(12'h106, 16'h00FD);
      put(12'h108, 16'h6342);
      put(12'h10A, 16'h3342);
      put(12'h10C, 16'h00FD);
      put(12'h10E, 16'h00EE);
      start();
      check("reset_pc", pc, 16'h0100);
      check("reset_sp", 16'(cpu0.sp), 16'h0000);
      k = 0;
      for (int c = 0; c < 21; c++) begin
         if (16'(cpu0.state_r) == ST_HALT) break;
         if ((16'(cpu0.state_r) == ST_FETCH_HI) && (k < 6)) begin
            check("trace_pc", pc, exp_trace[k]);
            k++;
         end
         @(negedge clk);
      end
      check("trace_len", 16'(k), 16'd6);
      check("s1_halt", 16'(cpu0.state_r), ST_HALT);
      check("s1_pc", pc, 16'h0106);
      check("s1_v3", 16'(cpu0.v[3]), 16'h0042);
      check("s1_sp", 16'(cpu0.sp), 16'h0000);

      // arithmetic, flags and flag-over-result when x = F
      begin_load();
      put(12'h100, 16'h6AFF);
      put(12'h102, 16'h6B01);
      put(12'h104, 16'h8AB4);
      put(12'h106, 16'h8AB5);
      put(12'h108, 16'h6F05);
      put(12'h10A, 16'h6103);
      put(12'h10C, 16'h8F14);
      put(12'h10E, 16'h6281);
      put(12'h110, 16'h8206);
      put(12'h112, 16'h6381);
      put(12'h114, 16'h830E);
      put(12'h116, 16'h6405);
      put(12'h118, 16'h6507);
      put(12'h11A, 16'h8457);
      put(12'h11C, 16'h7AFE);
      put(12'h11E, 16'h60FF);
      put(12'h120, 16'hC000);
      put(12'h122, 16'h00FD);
      start();
      cycles(9);
      check("add_va", 16'(cpu0.v[10]), 16'h0000);
      check("add_vf", 16'(cpu0.v[15]), 16'h0001);
      cycles(3);
      check("sub_va", 16'(cpu0.v[10]), 16'h00FF);
      check("sub_vf", 16'(cpu0.v[15]), 16'h0000);
      cycles(9);
      check("flagwins_vf", 16'(cpu0.v[15]), 16'h0000);
      cycles(6);
      check("shr_v2", 16'(cpu0.v[2]), 16'h0040);
      check("shr_vf", 16'(cpu0.v[15]), 16'h0001);
      cycles(6);
      check("shl_v3", 16'(cpu0.v[3]), 16'h0002);
      check("shl_vf", 16'(cpu0.v[15]), 16'h0001);
      cycles(9);
      check("subn_v4", 16'(cpu0.v[4]), 16'h0002);
      check("subn_vf", 16'(cpu0.v[15]), 16'h0001);
      cycles(3);
      check("addi_va", 16'(cpu0.v[10]), 16'h00FD);
      check("addi_vf", 16'(cpu0.v[15]), 16'h0001);
      cycles(6);
      check("rnd_mask0", 16'(cpu0.v[0]), 16'h0000);
      run_to_halt(10, "s2_halt");
      check("s2_pc", pc, 16'h0122);

      // block store / load
      begin_load();
      put(12'h100, 16'hA300);
      put(12'h102, 16'h6012);
      put(12'h104, 16'h6134);
      put(12'h106, 16'hF155);
      put(12'h108, 16'h6000);
      put(12'h10A, 16'h6100);
      put(12'h10C, 16'hF165);
      put(12'h10E, 16'hF01E);
      put(12'h110, 16'h00FD);
      start();
      cycles(23);
      check("st_mem300", 16'(cpu0.mem[12'h300]), 16'h0012);
      check("st_mem301", 16'(cpu0.mem[12'h301]), 16'h0034);
      check("st_mem302", 16'(cpu0.mem[12'h302]), 16'h0000);
      check("ld_v0", 16'(cpu0.v[0]), 16'h0012);
      check("ld_v1", 16'(cpu0.v[1]), 16'h0034);
      check("ld_i", 16'(cpu0.i_r), 16'h0300);
      check("ld_pc", pc, 16'h010E);
      run_to_halt(10, "s3_halt");
      check("addi_i", 16'(cpu0.i_r), 16'h0312);

      // 17 nested calls wrap SP, then return via stack[0]
      begin_load();
      for (int c = 0; c < 16; c++) put(12'(12'h100 + 2 * c), 16'(16'h2102 + 2 * c));
      put(12'h120, 16'h2200);
      put(12'h122, 16'h00FD);
      put(12'h200, 16'h00EE);
      start();
      cycles(51);
      check("wrap_sp", 16'(cpu0.sp), 16'h0001);
      check("wrap_pc", pc, 16'h0200);
      run_to_halt(12, "s4_halt");
      check("ret_pc", pc, 16'h0122);
      check("ret_sp", 16'(cpu0.sp), 16'h0000);

      // reset in the middle of a store loop
      begin_load();
      put(12'h100, 16'h6512);
      put(12'h102, 16'hA300);
      put(12'h104, 16'hFF55);
      put(12'h106, 16'h00FD);
      start();
      cycles(10);
      check("loop_state", 16'(cpu0.state_r), ST_EXEC);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_pc", pc, 16'h0100);
      check("midrst_state", 16'(cpu0.state_r), ST_FETCH_HI);
      check("midrst_v5", 16'(cpu0.v[5]), 16'h0000);
      check("midrst_i", 16'(cpu0.i_r), 16'h0000);
      check("midrst_sp", 16'(cpu0.sp), 16'h0000);

      // skips, jump and pc wrap
      begin_load();
      put(12'h100, 16'h6342);
      put(12'h102, 16'h4342);
      put(12'h104, 16'h6442);
      put(12'h106, 16'h5340);
      put(12'h10A, 16'h3341);
      put(12'h10C, 16'h9340);
      put(12'h10E, 16'h1FFE);
      put(12'hFFE, 16'h7301);
      put(12'h000, 16'h00FD);
      start();
      cycles(6);
      check("sne_not_taken", pc, 16'h0104);
      cycles(6);
      check("se_reg_taken", pc, 16'h010A);
      cycles(6);
      check("no_skips", pc, 16'h010E);
      cycles(3);
      check("jp_pc", pc, 16'h0FFE);
      cycles(3);
      check("wrap_pc0", pc, 16'h0000);
      check("wrap_v3", 16'(cpu0.v[3]), 16'h0043);
      run_to_halt(6, "s6_halt");
      cycles(5);
      check("halt_hold_pc", pc, 16'h0000);
      check("halt_hold_state", 16'(cpu0.state_r), ST_HALT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h100, meaning the program start address loaded at reset and power-up.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have port pc, output, 16 bits, meaning the current program counter; bits [15:12] are always 0.
REQ-005 SHALL contain an internal memory named mem: 4096 x 8 bits, byte-addressed, big-endian instructions, loadable hierarchically by a bench (cpu0.mem[a]).

Function
REQ-006 SHALL hold V0..VF (8 bits each), I (12 bits), a 16-entry x 12-bit stack, a 4-bit SP, an LFSR and a state register.
REQ-007 SHALL run the states FETCH_HI -> FETCH_LO -> EXEC -> FETCH_HI, one cycle each; exceptions are the LD loops (REQ-014) and HALT.
REQ-008 SHALL read memory combinationally: FETCH_HI latches mem[pc]; FETCH_LO latches mem[pc+1].
REQ-009 SHALL advance pc in EXEC to pc+2 by default, to pc+4 on a taken skip, and to the target on a jump, call or return; pc arithmetic wraps modulo 4096.
REQ-010 SHALL execute 0000 and every undefined opcode as NOP; 00EE as RET (SP-1, pc = stack[SP]); 00FD as EXIT (go to HALT, pc unchanged).
REQ-011 SHALL execute 1nnn as JP (pc = nnn); 2nnn as CALL (stack[SP] = pc+2, SP+1, pc = nnn); Bnnn as pc = nnn+V0.
REQ-012 SHALL execute skips 3xkk (Vx==kk), 4xkk (Vx!=kk), 5xy0 (Vx==Vy) and 9xy0 (Vx!=Vy).
REQ-013 SHALL execute 6xkk (Vx = kk), 7xkk (Vx += kk, VF unchanged), Annn (I = nnn), Fx1E (I += Vx, mod 4096) and Cxkk (Vx = LFSR & kk).
REQ-014 SHALL execute Fx55 (mem[I+i] = Vi) and Fx65 (Vi = mem[I+i]) for i = 0..x, one register per cycle (x+1 EXEC cycles), with I unchanged and pc+2 after the last.
REQ-015 SHALL execute 8xy0/1/2/3 as LD/OR/AND/XOR; 8xy4 ADD with VF = carry; 8xy5 SUB with VF = NOT borrow (Vx>=Vy); 8xy7 SUBN with VF = (Vy>=Vx); 8xy6 SHR Vx with VF = old bit 0; 8xyE SHL Vx with VF = old bit 7.
REQ-016 SHALL, when x = F in an 8xy instruction, write the flag after the result (flag wins).
REQ-017 SHALL wrap SP modulo 16 on overflow (CALL at SP 15) and underflow (RET at SP 0), with no error signalled.
REQ-018 SHALL, in HALT, hold pc and all state until reset.
REQ-019 SHALL implement the LFSR as a 16-bit maximal-length LFSR with a non-zero seed, advancing every cycle.

Reset
REQ-020 SHALL, on reset, set pc = RESET_PC, SP = 0, I = 0, V0..VF = 0 and state = FETCH_HI, leave HALT, and reseed the LFSR.
REQ-021 SHALL give reset priority over any in-progress instruction or loop; mem and stack contents are not cleared.
REQ-022 SHALL initialise pc = RESET_PC and state = FETCH_HI at power-up, without reset.

Verification
REQ-023 SHALL pass this scenario: load 100:1104, 104:2108, 106:00FD, 108:6342, 10A:3342, 10C:00FD, 10E:00EE and run -> pc sequence 100,104,108,10A,10E,106, then HALT at pc 106 with V3 = 42 and SP = 0, all by cycle 20.
REQ-024 SHALL pass this scenario: 6AFF, 6B01, 8AB4 -> VA = 00, VF = 1; then 8AB5 -> VA = FF, VF = 0.
REQ-025 SHALL pass this scenario: A300, 6012, 6134, F155; then clear V0/V1 via 6000, 6100; then F165 -> mem[300] = 12, mem[301] = 34, V0 = 12, V1 = 34, I = 300.
REQ-026 SHALL pass this scenario: 17 nested CALLs -> SP wraps to 1 with no hang; a subsequent RET returns to stack[0].
REQ-027 SHALL pass this scenario: assert reset for 1 cycle mid-EXEC of an F-loop -> next cycle pc = 100, state FETCH_HI, registers 0.
REQ-028 SHALL pass this scenario: 4342 with V3 = 42 -> pc+2 (not taken); 5340 with V3 = V4 -> pc+4.
